// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for a dual-address FIFO memory
module fifo_ctrl #(
    parameter int MEM_LENGHT = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int UMBRAL_AF  = 6,
    parameter int UMBRAL_AE  = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

    assign write_addr   = wr_ptr;
    assign read_addr    = rd_ptr;
    assign full         = count == (ADDR_WIDTH+1)'(MEM_LENGHT);
    assign empty        = count == '0;
    assign almost_full  = count >= (ADDR_WIDTH+1)'(UMBRAL_AF);
    assign almost_empty = count <= (ADDR_WIDTH+1)'(UMBRAL_AE);
    assign write_enable = push & ~full & reset_L;
    assign read_enable  = pop & ~empty & reset_L;

    // Advance pointers on accepted accesses, track occupancy, flag rejected requests
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (write_enable) wr_ptr <= wr_ptr + 1'b1;
            if (read_enable) rd_ptr <= rd_ptr + 1'b1;
            count      <= count + (ADDR_WIDTH+1)'(write_enable) - (ADDR_WIDTH+1)'(read_enable);
            data_valid <= read_enable;
            if ((push & full) | (pop & empty)) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench with a queue-based FIFO reference model and a memory model
module tb_fifo_ctrl;
    logic        clk = 1'b0;
    logic        reset_L, push, pop;
    logic [2:0]  write_addr, read_addr;
    logic        write_enable, read_enable, data_valid;
    logic [3:0]  count;
    logic        full, empty, almost_full, almost_empty, error;
    logic [11:0] din, dout;
    logic [11:0] mem [8];
    logic [11:0] ref_q[$];
    logic [11:0] exp_q[$];
    int n_chk = 0, n_fail = 0;
    int m_cnt, m_wa, m_ra, seq;
    bit m_err, m_dv;

    fifo_ctrl dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
        .write_addr(write_addr), .read_addr(read_addr),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_valid(data_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .error(error)
    );

    always #5 clk = ~clk;

    // Downstream memory: writes on accepted push, registers output on accepted pop
    always @(posedge clk) begin
        if (write_enable) mem[write_addr] <= din;
        if (read_enable) dout <= mem[read_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented word must be the next one the model popped
    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) chk("unexpected_data_valid", 1, 0);
            else begin : pop_exp
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("data_out", int'(dout), int'(e));
            end
        end
    end

    task automatic check_state();
        chk("count", int'(count), m_cnt);
        chk("full", int'(full), int'(m_cnt == 8));
        chk("empty", int'(empty), int'(m_cnt == 0));
        chk("almost_full", int'(almost_full), int'(m_cnt >= 6));
        chk("almost_empty", int'(almost_empty), int'(m_cnt <= 2));
        chk("error", int'(error), int'(m_err));
        chk("data_valid", int'(data_valid), int'(m_dv));
        chk("write_addr", int'(write_addr), m_wa);
        chk("read_addr", int'(read_addr), m_ra);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wa = 0; m_ra = 0; m_err = 0; m_dv = 0;
        ref_q.delete();
        exp_q.delete();
    endtask

    task automatic cycle(input bit p, input bit q);
        bit wa, ra;
        push = p;
        pop  = q;
        din  = seq[11:0];
        #1;
        wa = p && m_cnt < 8;
        ra = q && m_cnt > 0;
        check_state();
        chk("write_enable", int'(write_enable), int'(wa));
        chk("read_enable", int'(read_enable), int'(ra));
        if (wa) begin
            ref_q.push_back(seq[11:0]);
            seq++;
            m_wa = (m_wa + 1) % 8;
        end
        if (ra) begin
            exp_q.push_back(ref_q.pop_front());
            m_ra = (m_ra + 1) % 8;
        end
        m_cnt = m_cnt + int'(wa) - int'(ra);
        m_err = m_err || (p && !wa) || (q && !ra);
        m_dv  = ra;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        push = 1'b1;
        pop  = 1'b1;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("write_enable_rst", int'(write_enable), 0);
        chk("read_enable_rst", int'(read_enable), 0);
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        din = '0;
        seq = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        reset_L = 1'b1;
        // Fill with 0x001..0x008, then one push too many
        repeat (9) cycle(1, 0);
        // Drain in order, then one pop too many
        repeat (9) cycle(0, 1);
        cycle(0, 0);
        do_reset();
        // Wrap pointers past 7
        repeat (5) cycle(1, 0);
        repeat (5) cycle(0, 1);
        repeat (6) cycle(1, 0);
        repeat (6) cycle(0, 1);
        cycle(0, 0);
        // Simultaneous at count 4, 8 and 0
        repeat (4) cycle(1, 0);
        cycle(1, 1);
        repeat (4) cycle(1, 0);
        cycle(1, 1);
        repeat (7) cycle(0, 1);
        cycle(1, 1);
        cycle(0, 0);
        do_reset();
        // Back-to-back streaming at count 3
        repeat (3) cycle(1, 0);
        repeat (20) cycle(1, 1);
        // Mid-burst reset
        do_reset();
        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (2) cycle(0, 0);
        chk("pending_reads", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
